// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one-deep IF/ID slot with a skid entry,
// redirect/exception steering and discard of in-flight stale reads.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] pc
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_n;
  logic [31:0] addr;
  logic [31:0] addr_n;
  logic [31:0] pc_n;
  logic        req_n;
  logic        valid_n;
  logic [31:0] if_pc_n;
  logic [31:0] instr_n;
  logic        skid_valid;
  logic        skid_valid_n;
  logic [31:0] skid_pc;
  logic [31:0] skid_pc_n;
  logic [31:0] skid_instr;
  logic [31:0] skid_instr_n;

  logic        flush;
  logic        consumed;
  logic        free;
  logic [31:0] tgt;
  logic [31:0] pc4;

  assign flush    = redirect | exc;
  assign tgt      = exc ? EXC_VEC : redirect_pc;
  assign consumed = if_valid & ~stall;
  assign free     = ~if_valid | consumed;
  assign pc4      = pc + 32'd4;

  // addr holds the outstanding request, which can differ from pc
  // once a redirect has been taken during DISCARD.
  assign imem_addr = addr;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    req_n        = imem_req;
    addr_n       = addr;
    valid_n      = if_valid;
    if_pc_n      = if_pc;
    instr_n      = if_instr;
    skid_valid_n = skid_valid;
    skid_pc_n    = skid_pc;
    skid_instr_n = skid_instr;
    unique case (1'b1)
      (state == IDLE): begin
        state_n = FETCH;
        req_n   = 1'b1;
        addr_n  = pc;
      end
      (state == FETCH): begin
        if (flush) begin
          pc_n         = tgt;
          valid_n      = 1'b0;
          skid_valid_n = 1'b0;
          if (imem_req && !imem_ack) begin
            state_n = DISCARD;
          end else begin
            req_n  = 1'b1;
            addr_n = tgt;
          end
        end else if (imem_req && imem_ack) begin
          pc_n = pc4;
          if (free) begin
            instr_n = imem_rdata;
            if_pc_n = pc;
            valid_n = 1'b1;
            req_n   = 1'b1;
            addr_n  = pc4;
          end else begin
            skid_instr_n = imem_rdata;
            skid_pc_n    = pc;
            skid_valid_n = 1'b1;
            req_n        = 1'b0;
            state_n      = HOLD;
          end
        end else begin
          if (consumed) begin
            valid_n = 1'b0;
          end
          if (!imem_req && free) begin
            req_n  = 1'b1;
            addr_n = pc;
          end
        end
      end
      (state == HOLD): begin
        if (flush) begin
          pc_n         = tgt;
          valid_n      = 1'b0;
          skid_valid_n = 1'b0;
          state_n      = FETCH;
          req_n        = 1'b1;
          addr_n       = tgt;
        end else if (!stall) begin
          instr_n      = skid_instr;
          if_pc_n      = skid_pc;
          valid_n      = skid_valid;
          skid_valid_n = 1'b0;
          state_n      = FETCH;
          req_n        = 1'b1;
          addr_n       = pc;
        end
      end
      (state == DISCARD): begin
        if (flush) begin
          pc_n         = tgt;
          valid_n      = 1'b0;
          skid_valid_n = 1'b0;
        end
        // stale data is dropped; restart at the newest target
        if (imem_ack) begin
          state_n = FETCH;
          req_n   = 1'b1;
          addr_n  = flush ? tgt : pc;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      imem_req   <= 1'b0;
      addr       <= RESET_PC;
      if_valid   <= 1'b0;
      if_pc      <= 32'd0;
      if_instr   <= 32'd0;
      skid_valid <= 1'b0;
      skid_pc    <= 32'd0;
      skid_instr <= 32'd0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      imem_req   <= req_n;
      addr       <= addr_n;
      if_valid   <= valid_n;
      if_pc      <= if_pc_n;
      if_instr   <= instr_n;
      skid_valid <= skid_valid_n;
      skid_pc    <= skid_pc_n;
      skid_instr <= skid_instr_n;
    end
  end

endmodule
